// File: rtl/demux_1a2_pkg.sv
// Shared constants for the two-lane mux/demux data path.
// Lane indices and the default word width live here.
package demux_1a2_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    function automatic logic other_lane(input logic lane);
        return ~lane;
    endfunction

endpackage

// File: rtl/demux_1a2_fifo_sync.sv
// Synchronous show-ahead FIFO: head word is presented on data_out.
// DEPTH must be a power of two so the pointers wrap for free.
module fifo_sync
    import demux_1a2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign data_out = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are dropped here.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale words are never visible past empty.
    always_ff @(posedge clk) begin
        if (reset_L && do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/demux_1a2.sv
// Splits the interleaved word stream back into lane 0 and lane 1.
// Strict alternation: a full target lane stalls input, never skips it.
module demux_1a2
    import demux_1a2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic                  valid_out_0,
    input  logic                  pop_0,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  valid_out_1,
    input  logic                  pop_1,
    output logic                  error_out
);

    logic sel_q, sel_d;
    logic error_q, error_d;

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;

    logic [DATA_WIDTH-1:0] head_0;
    logic [DATA_WIDTH-1:0] head_1;

    logic accept;

    // Depends only on registered state, never on same-cycle pops.
    assign ready_in = !full[sel_q];
    assign accept   = valid_in && ready_in;

    assign push[LANE0] = accept && (sel_q == LANE0);
    assign push[LANE1] = accept && (sel_q == LANE1);

    always_comb begin
        sel_d   = sel_q;
        error_d = error_q;
        if (accept) begin
            sel_d = other_lane(sel_q);
        end
        if ((pop_0 && empty[LANE0]) || (pop_1 && empty[LANE1])) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sel_q   <= LANE0;
            error_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            error_q <= error_d;
        end
    end

    fifo_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_0 (
        .clk      (clk),
        .reset_L  (reset_L),
        .push     (push[LANE0]),
        .pop      (pop_0),
        .data_in  (data_in),
        .data_out (head_0),
        .full     (full[LANE0]),
        .empty    (empty[LANE0])
    );

    fifo_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_1 (
        .clk      (clk),
        .reset_L  (reset_L),
        .push     (push[LANE1]),
        .pop      (pop_1),
        .data_in  (data_in),
        .data_out (head_1),
        .full     (full[LANE1]),
        .empty    (empty[LANE1])
    );

    assign valid_out_0 = !empty[LANE0];
    assign valid_out_1 = !empty[LANE1];
    assign data_out_0  = valid_out_0 ? head_0 : '0;
    assign data_out_1  = valid_out_1 ? head_1 : '0;
    assign error_out   = error_q;

endmodule

// File: doc/demux_1a2.md
# demux_1a2

Demultiplexer for the two-lane data path. It takes the single interleaved 8-bit word stream and splits it back into lane 0 and lane 1. Words are assigned strictly alternately, and each lane has its own small FIFO with a pop interface toward the consumer. Input backpressure is applied through `ready_in` so that word order is never lost.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width.
- `DEPTH`, 4: entries per lane FIFO; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_L`, in, 1: synchronous, active-low reset.
- `data_in`, in, DATA_WIDTH: interleaved input word.
- `valid_in`, in, 1: `data_in` is valid this cycle.
- `ready_in`, out, 1: block can accept the word offered this cycle.
- `data_out_0`, out, DATA_WIDTH: head of the lane 0 FIFO (show-ahead).
- `valid_out_0`, out, 1: lane 0 FIFO is not empty.
- `pop_0`, in, 1: consumer takes the lane 0 head.
- `data_out_1`, out, DATA_WIDTH: head of the lane 1 FIFO.
- `valid_out_1`, out, 1: lane 1 FIFO is not empty.
- `pop_1`, in, 1: consumer takes the lane 1 head.
- `error_out`, out, 1: sticky flag; set by a pop on an empty lane.

## Operation
- Selector register `sel` (1 bit) gives the target lane of the next input word. Reset value is 0, so the first word goes to lane 0.
- Accept condition: `valid_in && ready_in`, where `ready_in = !full[sel]`.
  - `ready_in` is combinational from registered state only. It does not depend on this cycle's pops.
- On accept:
  - Word is pushed into FIFO[`sel`].
  - `sel` toggles.
- If the target FIFO is full:
  - `ready_in` = 0, the word is not taken and `sel` holds.
  - The source must hold the word; the other lane's free space is never used out of order.
- Pop: when `pop_N && valid_out_N`, the head of FIFO N is removed.
  - A pop on an empty lane is ignored and sets `error_out`.
- Push and pop on the same non-full lane in the same cycle: both happen; occupancy is unchanged.
  - A full lane cannot be pushed that cycle even if it is popped (`ready_in` was 0).
- `data_out_N` is 0 whenever `valid_out_N` = 0.
- Occupancy counter per lane is `$clog2(DEPTH)+1` bits wide.
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Reset (`reset_L` = 0 at a rising edge), including mid-stream:
  - `sel` = 0, both FIFOs empty with pointers = 0, `error_out` = 0.
  - All buffered words are discarded; no pushes or pops take effect during that cycle.

## Timing
- Reset values, visible the cycle after the reset edge:
  - `valid_out_0` = `valid_out_1` = 0.
  - `data_out_0` = `data_out_1` = 0.
  - `error_out` = 0.
  - `ready_in` = 1.
- Latency: a word accepted at edge k appears on `data_out_N` with `valid_out_N` = 1 after edge k (1 cycle).
- Pop at edge k: the next head (or `valid_out_N` = 0) is presented after edge k.
- `ready_in` falls in the cycle after the push that fills the target lane. It rises the cycle after a pop frees that lane.
- Throughput: 1 word/cycle on input when both lanes are drained at least every other cycle.

## Structure
- Shared defines file (also included by the mux side):
  - `DATA_WIDTH` default.
  - Lane index constants `LANE0` = 0, `LANE1` = 1.
- One sub-module, `fifo_sync`: synchronous show-ahead FIFO.
  - Parameters `DATA_WIDTH`, `DEPTH`.
  - Ports: push, pop, `data_in`, `data_out`, `full`, `empty`, `reset_L`.
- Instantiated twice. The top level holds `sel`, the accept logic, `error_out` and output zeroing.

## Test plan
- Reset, then stream 0xA0, 0xA1, 0xA2, 0xA3 with both lanes popped every cycle -> lane 0 sees 0xA0, 0xA2 and lane 1 sees 0xA1, 0xA3, each 1 cycle after accept.
- No pops, continuous `valid_in`, 10 words 0x00..0x09 (DEPTH=4):
  - 0x00..0x07 are accepted.
  - `ready_in` = 0 from the cycle 0x08 is offered, and `sel` stays 0.
  - Popping lane 0 once -> 0x08 is accepted the following cycle.
- Lane 1 full, lane 0 empty, `sel` = 1 -> `ready_in` = 0. The word is not written to lane 0, and lane 0 stays empty.
- Simultaneous push and pop on lane 0 with occupancy 2 -> occupancy stays 2, FIFO order is preserved, and the pointers wrap correctly over 12 words.
- `pop_1` while lane 1 is empty -> `error_out` = 1 and remains 1 until reset. FIFO state is unchanged.
- Reset asserted with 3 words buffered -> next cycle both `valid_out` = 0, `data_out` = 0 and `ready_in` = 1. The first new word goes to lane 0.
